// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel stage: two line buffers plus a
// shifting 3x3 register window, with border windows suppressed from out_valid.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8,
    localparam int CW = $clog2(IMG_WIDTH),
    localparam int RW = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic [PIX_W-1:0] pixel0,
    output logic [PIX_W-1:0] pixel1,
    output logic [PIX_W-1:0] pixel2,
    output logic [PIX_W-1:0] pixel3,
    output logic [PIX_W-1:0] pixel4,
    output logic [PIX_W-1:0] pixel5,
    output logic [PIX_W-1:0] pixel6,
    output logic [PIX_W-1:0] pixel7,
    output logic [PIX_W-1:0] pixel8,
    output logic [CW-1:0]    out_col,
    output logic [RW-1:0]    out_row
);

    logic [CW-1:0]    col, cur_col;
    logic [RW-1:0]    row, cur_row;
    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] lb0_q, lb1_q;
    logic [PIX_W-1:0] win [9];

    // sof forces the current pixel to (0,0) before any wrap logic sees it
    always_comb begin
        cur_col = in_sof ? '0 : col;
        cur_row = in_sof ? '0 : row;
    end

    assign lb0_q = lb0[cur_col];
    assign lb1_q = lb1[cur_col];

    // Line buffers are not reset; border gating hides stale contents.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0[cur_col] <= lb1_q;
            lb1[cur_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            out_row   <= '0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (cur_col == CW'(IMG_WIDTH - 1)) begin
                    col <= '0;
                    row <= (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= win[3*r+1];
                    win[3*r+1] <= win[3*r+2];
                end
                win[2]    <= lb0_q;
                win[5]    <= lb1_q;
                win[8]    <= in_pixel;
                out_valid <= (cur_col >= CW'(2)) && (cur_row >= RW'(2));
                out_col   <= cur_col - CW'(1);
                out_row   <= cur_row - RW'(1);
            end
        end
    end

    assign pixel0 = win[0];
    assign pixel1 = win[1];
    assign pixel2 = win[2];
    assign pixel3 = win[3];
    assign pixel4 = win[4];
    assign pixel5 = win[5];
    assign pixel6 = win[6];
    assign pixel7 = win[7];
    assign pixel8 = win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: directed frame scenarios with random pixel data,
// checked against a coordinate-indexed image model of the window contents.
module tb_sobel_window_gen;
    localparam int W = 8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = '0;
    logic       out_valid;
    logic [7:0] pix [9];
    logic [2:0] out_col;
    logic [1:0] out_row;

    int total = 0;
    int passed = 0;

    // model state
    int         mcol = 0, mrow = 0;
    logic [7:0] img [H][W];
    logic [7:0] ex [9];
    int         ecol = 0, erow = 0;
    bit         known = 1'b0;
    int         nvalid = 0;
    logic [7:0] fr [W*H];
    logic [7:0] fr2 [W*H];

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .out_valid(out_valid),
        .pixel0(pix[0]), .pixel1(pix[1]), .pixel2(pix[2]),
        .pixel3(pix[3]), .pixel4(pix[4]), .pixel5(pix[5]),
        .pixel6(pix[6]), .pixel7(pix[7]), .pixel8(pix[8]),
        .out_col(out_col), .out_row(out_row)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_window(input string tag);
        for (int k = 0; k < 9; k++) chk($sformatf("%s pixel%0d", tag, k), 32'(pix[k]), 32'(ex[k]));
        chk({tag, " out_col"}, 32'(out_col), 32'(ecol));
        chk({tag, " out_row"}, 32'(out_row), 32'(erow));
    endtask

    task automatic send(input logic [7:0] v, input bit sof);
        int pc, pr;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = v;
        pc = sof ? 0 : mcol;
        pr = sof ? 0 : mrow;
        img[pr][pc] = v;
        if (pc == W - 1) begin
            mcol = 0;
            mrow = (pr == H - 1) ? 0 : pr + 1;
        end else begin
            mcol = pc + 1;
            mrow = pr;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (pc >= 2 && pr >= 2) begin
            for (int k = 0; k < 9; k++) ex[k] = img[pr - 2 + k / 3][pc - 2 + k % 3];
            ecol = pc - 1;
            erow = pr - 1;
            known = 1'b1;
            nvalid++;
            chk("valid window out_valid", 32'(out_valid), 32'd1);
            chk_window("valid window");
        end else begin
            known = 1'b0;
            chk("border out_valid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'($urandom);
        in_pixel = 8'($urandom);
        @(posedge clk); #1;
        in_sof = 1'b0;
        chk("idle out_valid", 32'(out_valid), 32'd0);
        if (known) chk_window("idle hold");
    endtask

    task automatic send_frame(input bit second, input bit gaps, input bit sof);
        for (int i = 0; i < W * H; i++) begin
            send(second ? fr2[i] : fr[i], sof && (i == 0));
            if (gaps) idle();
        end
    endtask

    task automatic model_reset();
        mcol = 0;
        mrow = 0;
        for (int k = 0; k < 9; k++) ex[k] = '0;
        ecol = 0;
        erow = 0;
        known = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < W * H; i++) fr[i] = 8'(16 * (i / W) + (i % W));
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk_window("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1/2: ramp frame with sof
        nvalid = 0;
        for (int i = 0; i < 2 * W + 3; i++) send(fr[i], i == 0);
        chk("t1 first pixel4", 32'(pix[4]), 32'h11);
        chk("t1 first pixel0", 32'(pix[0]), 32'h00);
        chk("t1 first out_col", 32'(out_col), 32'd1);
        chk("t1 first count", 32'(nvalid), 32'd1);
        for (int i = 2 * W + 3; i < W * H; i++) send(fr[i], 1'b0);
        chk("t2 window count", 32'(nvalid), 32'd12);
        chk("t2 last pixel8", 32'(pix[8]), 32'h37);
        chk("t2 last out_col", 32'(out_col), 32'd6);
        chk("t2 last out_row", 32'(out_row), 32'd2);

        // Test 3: random frame with idle after every pixel
        for (int i = 0; i < W * H; i++) fr2[i] = 8'($urandom);
        nvalid = 0;
        send_frame(1'b1, 1'b1, 1'b1);
        chk("t3 window count", 32'(nvalid), 32'd12);

        // Test 4: sof at the pixel that would be row 1 col 5
        for (int i = 0; i < W + 5; i++) send(8'($urandom), i == 0);
        for (int i = 0; i < W * H; i++) fr2[i] = 8'($urandom);
        nvalid = 0;
        send(fr2[0], 1'b1);
        for (int i = 1; i < 2 * W + 2; i++) send(fr2[i], 1'b0);
        chk("t4 no early valid", 32'(nvalid), 32'd0);
        send(fr2[2 * W + 2], 1'b0);
        chk("t4 first after sof", 32'(nvalid), 32'd1);
        chk("t4 pixel4", 32'(pix[4]), 32'(fr2[W + 1]));
        for (int i = 2 * W + 3; i < W * H; i++) send(fr2[i], 1'b0);
        chk("t4 window count", 32'(nvalid), 32'd12);

        // Test 5: reset mid-frame, then ramp without sof
        for (int i = 0; i < 3 * W + 5; i++) send(fr[i], i == 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5 async out_valid", 32'(out_valid), 32'd0);
        chk_window("t5 async reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        nvalid = 0;
        send_frame(1'b0, 1'b0, 1'b0);
        chk("t5 window count", 32'(nvalid), 32'd12);
        chk("t5 last pixel8", 32'(pix[8]), 32'h37);

        // Test 6: two back-to-back random frames without sof, random gaps
        for (int i = 0; i < W * H; i++) fr2[i] = 8'($urandom);
        nvalid = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < W * H; i++) begin
                send(fr2[i], 1'b0);
                if ($urandom_range(3) == 0) idle();
            end
        chk("t6 window count", 32'(nvalid), 32'd24);
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
